// File: rtl/sound_playback_pkg.sv
// sound_playback_pkg
// Shared definitions for the sound playback path: RAM geometry of the
// 512x32 sound frame RAM, the default idle (mid-scale) sample level and the
// fetch FSM state encoding used by the top level.
package sound_playback_pkg;

  // Geometry of the sound frame RAM filled by the UART byte packer.
  localparam int SOUND_AW = 9;
  localparam int SOUND_DW = 32;

  // Mid-scale sample value used whenever nothing real is being played.
  localparam logic [7:0] IDLE_LEVEL_DEFAULT = 8'h80;

  // Fetch FSM states, kept as plain two-bit constants so older blocks that
  // compare raw state codes keep working.
  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t ST_IDLE = 2'd0;
  localparam fetch_state_t ST_REQ  = 2'd1;
  localparam fetch_state_t ST_WAIT = 2'd2;
  localparam fetch_state_t ST_LOAD = 2'd3;

endpackage

// File: rtl/sound_playback_pwm8.sv
// pwm8
// Eight-bit pulse width modulator: a free-running 8-bit counter compared
// against the requested level, with a registered output.
// Ports:
//   clk      system clock
//   reset    asynchronous, active-high
//   level_i  8-bit duty level (0 = always low, 255 = high 255 of 256 cycles)
//   pwm_o    registered PWM output
module pwm8 (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] level_i,
  output logic       pwm_o
);

  logic [7:0] cnt_q;
  logic       pwm_q;

  // The counter wraps naturally at 256, so over any 256 consecutive cycles
  // with a steady level the output is high exactly level_i times.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 8'd0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 8'd1;
      pwm_q <= (cnt_q < level_i);
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/sound_playback.sv
// sound_playback
// Reads packed 32-bit words from the sound frame RAM, unpacks them LSB byte
// first into 8-bit samples (one per sample_tick) and drives a PWM output.
// Every rising edge of msec restarts playback at address 0; reads never go
// past the number of words the write side has committed this frame.
// Ports:
//   clk, reset    system clock, asynchronous active-high reset
//   msec          frame strobe level, rising edge = frame tick
//   sample_tick   one-cycle pulse at the audio sample rate
//   wr_level      words committed to RAM since the last frame tick (0..512)
//   rd_sound      RAM read address
//   q_sound       RAM read data, valid RD_LAT cycles after rd_sound changes
//   sample        current audio sample
//   sample_valid  one-cycle pulse when sample updates
//   pwm_out       PWM rendering of sample
//   underrun      sticky underrun flag, cleared on frame tick
//   playing       high from the first frame tick until reset
module sound_playback
  import sound_playback_pkg::*;
#(
  parameter int         RD_LAT     = 2,
  parameter logic [7:0] IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                msec,
  input  logic                sample_tick,
  input  logic [9:0]          wr_level,
  output logic [SOUND_AW-1:0] rd_sound,
  input  logic [SOUND_DW-1:0] q_sound,
  output logic [7:0]          sample,
  output logic                sample_valid,
  output logic                pwm_out,
  output logic                underrun,
  output logic                playing
);

  localparam logic [1:0] WAIT_LAST = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  logic                msec_q;
  logic                fr;
  fetch_state_t        state_q, state_d;
  logic [1:0]          waitCnt_q, waitCnt_d;
  logic [9:0]          rdPtr_q;
  logic [SOUND_AW-1:0] rdAddr_q;
  logic                issue;
  logic                load;
  logic [SOUND_DW-1:0] nxt_q, cur_q;
  logic                nxtValid_q, curValid_q;
  logic [1:0]          idx_q;
  logic [7:0]          sample_q;
  logic                sampleValid_q;
  logic                underrun_q;
  logic                playing_q;
  logic [7:0]          curByte;

  // Frame tick edge detector. The history register comes out of reset high
  // so a msec level that is already high at reset release is not mistaken
  // for a rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msec_q <= 1'b1;
    end else begin
      msec_q <= msec;
    end
  end

  assign fr = msec & ~msec_q;

  // Fetch FSM next-state logic. A read is only issued when the next-word
  // buffer is free and the write side has committed the word; the top bit
  // of the pointer stops reads once all 512 words have been fetched. A frame
  // tick forces REQ from any state and suppresses a pending LOAD so a read
  // belonging to the previous frame is dropped.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    issue     = 1'b0;
    load      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_REQ: begin
        if (!nxtValid_q && !rdPtr_q[9] && (rdPtr_q < wr_level)) begin
          issue     = 1'b1;
          waitCnt_d = 2'd0;
          state_d   = (RD_LAT == 1) ? ST_LOAD : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (waitCnt_q == WAIT_LAST) begin
          state_d = ST_LOAD;
        end else begin
          waitCnt_d = waitCnt_q + 2'd1;
        end
      end
      default: begin
        load    = 1'b1;
        state_d = ST_REQ;
      end
    endcase
    if (fr) begin
      state_d = ST_REQ;
      issue   = 1'b0;
      load    = 1'b0;
    end
  end

  // Fetch FSM state, read pointer and the registered RAM address. The
  // address register only moves on an issued read, so it holds steady
  // through WAIT and LOAD as the RAM expects.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      waitCnt_q <= 2'd0;
      rdPtr_q   <= 10'd0;
      rdAddr_q  <= '0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      if (fr) begin
        rdPtr_q <= 10'd0;
      end else if (load) begin
        rdPtr_q <= rdPtr_q + 10'd1;
      end
      if (issue) begin
        rdAddr_q <= rdPtr_q[SOUND_AW-1:0];
      end
    end
  end

  assign curByte = cur_q[{idx_q, 3'b000} +: 8];

  // Play side: current word being unpacked plus a one-word prefetch buffer.
  // A tick with a valid current word emits the indexed byte; after the last
  // byte the prefetched word (if any) takes over in the same cycle. A tick
  // with nothing to play emits the idle level and raises the sticky
  // underrun flag. An empty current slot refills from the prefetch buffer
  // without waiting for a tick. LOAD only happens while the buffer is empty,
  // so filling and draining the buffer never collide. A frame tick flushes
  // everything except the last sample value and swallows a coincident tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nxt_q         <= '0;
      nxtValid_q    <= 1'b0;
      cur_q         <= '0;
      curValid_q    <= 1'b0;
      idx_q         <= 2'd0;
      sample_q      <= IDLE_LEVEL;
      sampleValid_q <= 1'b0;
      underrun_q    <= 1'b0;
      playing_q     <= 1'b0;
    end else begin
      sampleValid_q <= 1'b0;
      if (fr) begin
        playing_q  <= 1'b1;
        curValid_q <= 1'b0;
        nxtValid_q <= 1'b0;
        idx_q      <= 2'd0;
        underrun_q <= 1'b0;
      end else begin
        if (load) begin
          nxt_q      <= q_sound;
          nxtValid_q <= 1'b1;
        end
        if (sample_tick && playing_q && curValid_q) begin
          sample_q      <= curByte;
          sampleValid_q <= 1'b1;
          if (idx_q == 2'd3) begin
            idx_q <= 2'd0;
            if (nxtValid_q) begin
              cur_q      <= nxt_q;
              nxtValid_q <= 1'b0;
            end else begin
              curValid_q <= 1'b0;
            end
          end else begin
            idx_q <= idx_q + 2'd1;
          end
        end else begin
          if (sample_tick && playing_q) begin
            sample_q      <= IDLE_LEVEL;
            sampleValid_q <= 1'b1;
            underrun_q    <= 1'b1;
          end
          if (!curValid_q && nxtValid_q) begin
            cur_q      <= nxt_q;
            curValid_q <= 1'b1;
            nxtValid_q <= 1'b0;
            idx_q      <= 2'd0;
          end
        end
      end
    end
  end

  pwm8 uPwm (
    .clk     (clk),
    .reset   (reset),
    .level_i (sample_q),
    .pwm_o   (pwm_out)
  );

  assign rd_sound     = rdAddr_q;
  assign sample       = sample_q;
  assign sample_valid = sampleValid_q;
  assign underrun     = underrun_q;
  assign playing      = playing_q;

endmodule

// File: tb/tb_sound_playback.sv
// tb_sound_playback
// Directed bench for sound_playback: a behavioural model of the sound frame
// RAM with read data valid RD_LAT cycles after the address changes, and a
// linear sequence of frame ticks, sample ticks and checks.
module tb_sound_playback;

  localparam int RD_LAT = 2;

  logic        clk;
  logic        reset;
  logic        msec;
  logic        sample_tick;
  logic [9:0]  wr_level;
  logic [8:0]  rd_sound;
  logic [31:0] q_sound;
  logic [7:0]  sample;
  logic        sample_valid;
  logic        pwm_out;
  logic        underrun;
  logic        playing;

  logic [31:0] ram [512];
  logic [31:0] qStage;

  int checkCount = 0;
  int passCount  = 0;

  logic       satMon = 1'b0;
  int         addrChanges = 0;
  int         addrOrderErr = 0;
  logic [8:0] prevAddr = 9'd0;
  logic [9:0] nextAddr = 10'd0;

  sound_playback #(
    .RD_LAT     (RD_LAT),
    .IDLE_LEVEL (8'h80)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .msec         (msec),
    .sample_tick  (sample_tick),
    .wr_level     (wr_level),
    .rd_sound     (rd_sound),
    .q_sound      (q_sound),
    .sample       (sample),
    .sample_valid (sample_valid),
    .pwm_out      (pwm_out),
    .underrun     (underrun),
    .playing      (playing)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: one register stage, so data for a new address shows up in
  // the second cycle after the address changes (latency RD_LAT = 2).
  always @(posedge clk) begin
    qStage <= ram[rd_sound];
  end
  assign q_sound = qStage;

  // Address monitor for the saturation run: counts address changes and
  // flags any change that is not the next sequential address.
  always @(negedge clk) begin
    if (satMon && (rd_sound !== prevAddr)) begin
      addrChanges = addrChanges + 1;
      if ({1'b0, rd_sound} !== nextAddr) begin
        addrOrderErr = addrOrderErr + 1;
      end
      nextAddr = {1'b0, rd_sound} + 10'd1;
    end
    prevAddr = rd_sound;
  end

  // One comparison: counts it, and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // Drives one cycle of tick/frame inputs starting at a falling edge and
  // returns at the next falling edge with the inputs released.
  task automatic applyStimulus(input logic doTick, input logic doFrame);
    sample_tick = doTick;
    msec        = doFrame;
    @(negedge clk);
    sample_tick = 1'b0;
    msec        = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts pwm_out high samples over 256 consecutive cycles.
  task automatic countPwm(output int highCount);
    highCount = 0;
    for (int c = 0; c < 256; c++) begin
      @(negedge clk);
      if (pwm_out === 1'b1) highCount++;
    end
  endtask

  logic [7:0] basicExp [8];
  int         satErr;
  int         highCount;
  int         stuckCount;

  initial begin
    basicExp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    for (int a = 0; a < 512; a++) ram[a] = 32'h0;
    ram[0] = 32'h44332211;
    ram[1] = 32'h88776655;

    reset       = 1'b1;
    msec        = 1'b0;
    sample_tick = 1'b0;
    wr_level    = 10'd0;
    idleCycles(3);

    // Reset state.
    checkOutput("rstRdSound", 32'(rd_sound), 32'h0);
    checkOutput("rstSample", 32'(sample), 32'h80);
    checkOutput("rstValid", 32'(sample_valid), 32'h0);
    checkOutput("rstPwm", 32'(pwm_out), 32'h0);
    checkOutput("rstUnderrun", 32'(underrun), 32'h0);
    checkOutput("rstPlaying", 32'(playing), 32'h0);
    reset = 1'b0;
    idleCycles(3);

    // Ticks before the first frame tick do nothing.
    applyStimulus(1'b1, 1'b0);
    checkOutput("preFrameValid", 32'(sample_valid), 32'h0);
    checkOutput("preFrameSample", 32'(sample), 32'h80);

    // Basic order: two words, eight ticks.
    wr_level = 10'd2;
    applyStimulus(1'b0, 1'b1);
    checkOutput("playingAfterFr", 32'(playing), 32'h1);
    idleCycles(10);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput($sformatf("basicValid%0d", k), 32'(sample_valid), 32'h1);
      checkOutput($sformatf("basicSample%0d", k), 32'(sample), 32'(basicExp[k]));
      idleCycles(9);
    end
    checkOutput("basicUnderrun", 32'(underrun), 32'h0);

    // Underrun on the ninth tick; sticky until the next frame tick.
    applyStimulus(1'b1, 1'b0);
    checkOutput("urValid", 32'(sample_valid), 32'h1);
    checkOutput("urSample", 32'(sample), 32'h80);
    checkOutput("urFlag", 32'(underrun), 32'h1);
    idleCycles(20);
    checkOutput("urSticky", 32'(underrun), 32'h1);

    // Write-side gating: nothing committed, nothing read.
    wr_level = 10'd0;
    applyStimulus(1'b0, 1'b1);
    checkOutput("urCleared", 32'(underrun), 32'h0);
    stuckCount = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (rd_sound !== 9'd1) stuckCount++;
    end
    checkOutput("gateNoRead", 32'(stuckCount), 32'h0);
    wr_level = 10'd1;
    idleCycles(2);
    checkOutput("gateAddr0", 32'(rd_sound), 32'h0);
    idleCycles(8);
    applyStimulus(1'b1, 1'b0);
    checkOutput("gateFirstByte", 32'(sample), 32'h11);

    // Mid-frame restart with a tick coincident with the frame tick.
    wr_level = 10'd2;
    applyStimulus(1'b0, 1'b1);
    idleCycles(10);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput($sformatf("restartPre%0d", k), 32'(sample), 32'(basicExp[k]));
      idleCycles(4);
    end
    applyStimulus(1'b1, 1'b1);
    checkOutput("restartTickIgnored", 32'(sample_valid), 32'h0);
    checkOutput("restartSampleHeld", 32'(sample), 32'h33);
    idleCycles(10);
    applyStimulus(1'b1, 1'b0);
    checkOutput("restartFirstByte", 32'(sample), 32'h11);
    checkOutput("restartUnderrun", 32'(underrun), 32'h0);

    // Saturation: 512 words whose bytes count 0,1,2,... so tick n yields n mod 256.
    for (int a = 0; a < 512; a++) begin
      ram[a] = {8'(4*a+3), 8'(4*a+2), 8'(4*a+1), 8'(4*a)};
    end
    idleCycles(20);
    wr_level = 10'd512;
    satMon   = 1'b1;
    applyStimulus(1'b0, 1'b1);
    idleCycles(10);
    satErr = 0;
    for (int i = 0; i < 2048; i++) begin
      applyStimulus(1'b1, 1'b0);
      if (sample_valid !== 1'b1 || sample !== 8'(i)) satErr++;
      idleCycles(2);
    end
    checkOutput("satSamples", 32'(satErr), 32'h0);
    checkOutput("satNoUnderrunYet", 32'(underrun), 32'h0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("satTick2049Sample", 32'(sample), 32'h80);
    checkOutput("satTick2049Underrun", 32'(underrun), 32'h1);
    idleCycles(20);
    satMon = 1'b0;
    checkOutput("satLastAddr", 32'(rd_sound), 32'd511);
    checkOutput("satAddrChanges", 32'(addrChanges), 32'd512);
    checkOutput("satAddrOrder", 32'(addrOrderErr), 32'h0);

    // PWM at idle level 0x80.
    countPwm(highCount);
    checkOutput("pwmIdle", 32'(highCount), 32'd128);

    // PWM at 0x40, then reset mid-word.
    ram[0] = 32'h00000040;
    ram[1] = 32'hA5A5A5A5;
    wr_level = 10'd2;
    applyStimulus(1'b0, 1'b1);
    idleCycles(10);
    applyStimulus(1'b1, 1'b0);
    checkOutput("pwmSample", 32'(sample), 32'h40);
    idleCycles(4);
    countPwm(highCount);
    checkOutput("pwm40", 32'(highCount), 32'd64);
    checkOutput("preResetAddr", 32'(rd_sound), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midRstRdSound", 32'(rd_sound), 32'h0);
    checkOutput("midRstSample", 32'(sample), 32'h80);
    checkOutput("midRstValid", 32'(sample_valid), 32'h0);
    checkOutput("midRstPwm", 32'(pwm_out), 32'h0);
    checkOutput("midRstUnderrun", 32'(underrun), 32'h0);
    checkOutput("midRstPlaying", 32'(playing), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    idleCycles(3);
    applyStimulus(1'b1, 1'b0);
    checkOutput("postRstNoValid", 32'(sample_valid), 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/sound_playback.md
Name: sound_playback

Overview:
- Downstream consumer of the 512x32 sound frame RAM that the UART byte packer fills.
- Reads packed 32-bit words from the RAM read port and unpacks each into four 8-bit samples, LSB byte first.
- Presents one sample per sample_tick and drives an 8-bit PWM audio output.
- Restarts at address 0 on every frame tick, the rising edge of msec, in lockstep with the write side. Reading never overtakes the write side's committed word count.

Parameters:
- RD_LAT, 2: RAM read latency in clk cycles, from rd_sound change to q_sound valid; legal range 1..3.
- IDLE_LEVEL, 8'h80: sample value output when stopped or on underrun (mid-scale).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- msec  in  1  frame strobe level; rising edge = frame tick
- sample_tick  in  1  one-cycle pulse at audio sample rate
- wr_level  in  10  words committed to RAM since the last frame tick (0..512)
- rd_sound  out  9  RAM read address
- q_sound  in  32  RAM read data
- sample  out  8  current audio sample
- sample_valid  out  1  one-cycle pulse when sample updates
- pwm_out  out  1  PWM of sample
- underrun  out  1  sticky; cleared on frame tick
- playing  out  1  high between the first frame tick and reset

Behaviour:
- Reset values:
  - rd_sound=0, sample=IDLE_LEVEL, sample_valid=0, pwm_out=0, underrun=0, playing=0.
  - FSM in IDLE; cur_valid=nxt_valid=0; rd_ptr=0; PWM counter=0.
- Frame tick detection: msec is registered once and fr = msec & ~msec_q. The first tick after reset is taken from the registered value, so there is no false edge out of reset.
- Fetch FSM states: IDLE, REQ, WAIT, LOAD.
  - IDLE: on fr go to REQ, set playing=1.
  - REQ: if !nxt_valid and rd_ptr < wr_level, drive rd_sound=rd_ptr[8:0] and go to WAIT. Otherwise stay in REQ.
  - WAIT: count RD_LAT-1 cycles with rd_sound held, then go to LOAD.
  - LOAD: nxt <= q_sound, nxt_valid=1, rd_ptr++, go to REQ.
- Address limit: rd_ptr is 10 bits. When it reaches 512 it saturates and no further reads are issued until fr. It never wraps within a frame.
- Play side:
  - Holds cur word, cur_valid and a 2-bit byte index.
  - Byte order: idx0=[7:0], idx1=[15:8], idx2=[23:16], idx3=[31:24].
  - On sample_tick with cur_valid: sample <= byte[idx], sample_valid=1 next cycle, then idx++.
  - After idx3: if nxt_valid, cur <= nxt, nxt_valid=0, idx=0 (same cycle). Otherwise cur_valid=0.
  - When cur_valid=0 and nxt_valid=1, cur is loaded from nxt on the next clk without waiting for a tick.
- Underrun: sample_tick while playing=1 and cur_valid=0 gives sample <= IDLE_LEVEL, sample_valid=1, underrun=1. The tick is not counted as a consumed byte.
- Before the first fr (playing=0), ticks produce no sample_valid and sample stays IDLE_LEVEL.
- Frame tick priority: fr beats every other event in the same cycle.
  - rd_ptr=0, cur_valid=nxt_valid=0, idx=0, underrun=0.
  - The FSM goes to REQ and any in-flight read is discarded (the LOAD is suppressed).
  - sample holds its last value.
  - A sample_tick coincident with fr is ignored.
- PWM: 8-bit free-running counter; pwm_out = (cnt < sample), registered. sample=0 gives constant 0; 255 gives high for 255 of every 256 cycles.
- Reset mid-operation returns all state to reset values immediately. Nothing is recovered until the next fr.

Decomposition:
- Shared package holds:
  - SOUND_AW=9 (RAM address width) and SOUND_DW=32 (RAM data width).
  - The IDLE_LEVEL default.
  - The fetch FSM state enum.
- Sub-module: pwm8 (counter + comparator).
- Edge detection stays inline.

Test Plan:
- Basic order:
  - Stimulus: RAM word0=32'h44332211, word1=32'h88776655, wr_level=2, fr, then 8 ticks spaced 10 cycles.
  - Required: samples 11,22,33,44,55,66,77,88 in that order, underrun=0.
- Underrun:
  - Stimulus: continue with a 9th tick under the same setup.
  - Required: sample=80, underrun=1. underrun stays 1 until the next fr, then 0.
- Write-side gating:
  - Stimulus: wr_level=0 after fr.
  - Required: no rd_sound change and no RAM read for 100 cycles.
  - Stimulus: raise wr_level to 1.
  - Required: read of address 0 issued within 2 cycles, first tick yields word0[7:0].
- Mid-frame restart:
  - Stimulus: fr after 3 bytes played, with a tick in the same cycle as fr.
  - Required: that tick is ignored; the next tick yields word0[7:0] from address 0.
- Saturation:
  - Stimulus: wr_level=512, 2048+ ticks.
  - Required: addresses 0..511 are each read once, there is no read after 511, and underrun is set on tick 2049.
- PWM and reset:
  - Stimulus: sample=8'h40.
  - Required: pwm_out high for 64 of every 256 cycles.
  - Stimulus: assert reset mid-word.
  - Required: all outputs return to reset values within the same cycle.
